ov9281_init_seq: RTL and testbench

//  Power-up register sequencer for the OV9281 sensor. Sits directly upstream of ov9281_cfg

---
 rtl/ov9281_init_seq.sv | 212 +++++++++++++++++++++
 tb/tb_ov9281_init_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov9281_init_seq.sv
// ov9281_init_seq: power-up register sequencer for the OV9281 sensor.
// Walks a fixed {addr[15:0], data[7:0]} table and issues one ov9281_cfg write
// per entry. addr 16'hFFFF marks a delay entry of data milliseconds.
// Failed or timed-out requests are retried up to MAX_RETRIES times per entry.
// Optional feature: define OV9281_INIT_READBACK_EN to read back and compare
// every written register except entry 0 (self-clearing soft reset).
module ov9281_init_seq #(
    parameter int CLK_FREQ    = 50000000,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int MAX_RETRIES = 2,
    parameter int PWRUP_CYC   = CLK_FREQ / 50,
    parameter int MS_CYC      = CLK_FREQ / 1000,
    parameter int TIMEOUT_CYC = CLK_FREQ / 1000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    output logic [$clog2(NUM_REGS+1)-1:0] o_fail_idx,
    output logic                          o_cfg_start,
    output logic                          o_cfg_write,
    output logic                          o_cfg_read,
    output logic [DATA_WIDTH-1:0]         o_cfg_data,
    input  logic                          i_cfg_done,
    input  logic                          i_cfg_error,
    input  logic [7:0]                    i_cfg_rdata
);

    localparam int IW      = $clog2(NUM_REGS + 1);
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int DLY_MAX = 255 * MS_CYC;
    localparam int T_A     = (PWRUP_CYC > TIMEOUT_CYC) ? PWRUP_CYC : TIMEOUT_CYC;
    localparam int TMAX    = (T_A > DLY_MAX) ? T_A : DLY_MAX;
    localparam int TW      = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DELAY, S_DONE, S_FAIL
`ifdef OV9281_INIT_READBACK_EN
        , S_RB_ISSUE, S_RB_WAIT
`endif
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   retry;
    logic [TW-1:0]   timer;
    logic [23:0]     cur;
    logic [23:0]     ent_now;
    logic            can_retry;
    logic            timed_out;
    logic            timer_max;

    // Register table; entries past the default 8 are zero-length delays.
    function automatic logic [23:0] tbl(input logic [IW-1:0] i);
        case (int'(i))
            0:       tbl = 24'h0103_01;
            1:       tbl = 24'hFFFF_0A;
            2:       tbl = 24'h0100_00;
            3:       tbl = 24'h3820_40;
            4:       tbl = 24'h3821_00;
            5:       tbl = 24'h4F00_01;
            6:       tbl = 24'h3662_01;
            7:       tbl = 24'h0100_01;
            default: tbl = 24'hFFFF_00;
        endcase
    endfunction

    assign ent_now   = tbl(idx);
    assign can_retry = (retry < RW'(MAX_RETRIES));
    assign timed_out = (timer >= TW'(TIMEOUT_CYC - 1));
    assign timer_max = (timer == {TW{1'b1}});

`ifndef OV9281_INIT_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^i_cfg_rdata;
    assign o_cfg_read   = 1'b0;
`endif

    // Sequencer FSM; all outputs registered, request strobes are 1-cycle pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            retry       <= '0;
            timer       <= '0;
            cur         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_fail_idx  <= '0;
            o_cfg_start <= 1'b0;
            o_cfg_write <= 1'b0;
            o_cfg_data  <= '0;
`ifdef OV9281_INIT_READBACK_EN
            o_cfg_read  <= 1'b0;
`endif
        end else begin
            o_cfg_start <= 1'b0;
            o_cfg_write <= 1'b0;
`ifdef OV9281_INIT_READBACK_EN
            o_cfg_read  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                        o_error <= 1'b0;
                        idx     <= '0;
                        retry   <= '0;
                        timer   <= '0;
                        state   <= S_PWRUP;
                    end
                end
                S_PWRUP: begin
                    if (timer >= TW'(PWRUP_CYC - 1)) begin
                        timer <= '0;
                        state <= S_LOAD;
                    end else if (!timer_max) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOAD: begin
                    timer <= '0;
                    if (idx == IW'(NUM_REGS)) begin
                        state <= S_DONE;
                    end else begin
                        cur        <= ent_now;
                        o_cfg_data <= DATA_WIDTH'(ent_now);
                        state      <= (ent_now[23:8] == 16'hFFFF) ? S_DELAY : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_cfg_start <= 1'b1;
                    o_cfg_write <= 1'b1;
                    timer       <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout
                    if (i_cfg_done && !i_cfg_error) begin
`ifdef OV9281_INIT_READBACK_EN
                        state <= (idx != '0) ? S_RB_ISSUE : S_NEXT;
`else
                        state <= S_NEXT;
`endif
                    end else if (i_cfg_done || timed_out) begin
                        if (can_retry) begin
                            retry <= retry + 1'b1;
                            state <= S_ISSUE;
                        end else begin
                            state <= S_FAIL;
                        end
                    end else if (!timer_max) begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef OV9281_INIT_READBACK_EN
                S_RB_ISSUE: begin
                    o_cfg_start <= 1'b1;
                    o_cfg_read  <= 1'b1;
                    timer       <= '0;
                    state       <= S_RB_WAIT;
                end
                S_RB_WAIT: begin
                    // any readback problem restarts the entry at its write
                    if (i_cfg_done && !i_cfg_error && (i_cfg_rdata == cur[7:0])) begin
                        state <= S_NEXT;
                    end else if (i_cfg_done || timed_out) begin
                        if (can_retry) begin
                            retry <= retry + 1'b1;
                            state <= S_ISSUE;
                        end else begin
                            state <= S_FAIL;
                        end
                    end else if (!timer_max) begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                S_DELAY: begin
                    if (timer >= TW'(cur[7:0]) * TW'(MS_CYC)) begin
                        state <= S_NEXT;
                    end else if (!timer_max) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (idx != IW'(NUM_REGS)) idx <= idx + 1'b1;
                    retry <= '0;
                    state <= S_LOAD;
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                S_FAIL: begin
                    o_error    <= 1'b1;
                    o_fail_idx <= idx;
                    o_busy     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov9281_init_seq.sv
// Directed bench for ov9281_init_seq with a small ov9281_cfg responder model.
module tb_ov9281_init_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        o_busy, o_done, o_error;
    logic [3:0]  o_fail_idx;
    logic        o_cfg_start, o_cfg_write, o_cfg_read;
    logic [31:0] o_cfg_data;
    logic        i_cfg_done, i_cfg_error;
    logic [7:0]  i_cfg_rdata;

    ov9281_init_seq #(
        .PWRUP_CYC  (10),
        .MS_CYC     (4),
        .TIMEOUT_CYC(20)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_fail_idx (o_fail_idx),
        .o_cfg_start(o_cfg_start),
        .o_cfg_write(o_cfg_write),
        .o_cfg_read (o_cfg_read),
        .o_cfg_data (o_cfg_data),
        .i_cfg_done (i_cfg_done),
        .i_cfg_error(i_cfg_error),
        .i_cfg_rdata(i_cfg_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // responder control
    logic [23:0] nack_key   = 24'hFFFFFF;
    int          nack_n     = 0;
    int          nack_used  = 0;
    logic [23:0] silent_key = 24'hFFFFFF;
    logic [23:0] mm_key     = 24'hFFFFFF;
    int          mm_n       = 0;
    int          mm_used    = 0;

    logic [23:0] wr_data[$];
    int          wr_cyc[$];

    logic [23:0] exp_wr[7] = '{24'h010301, 24'h010000, 24'h382040, 24'h382100,
                               24'h4F0001, 24'h366201, 24'h010001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic clear_log;
        wr_data.delete();
        wr_cyc.delete();
        nack_key = 24'hFFFFFF; nack_n = 0; nack_used = 0;
        silent_key = 24'hFFFFFF;
        mm_key = 24'hFFFFFF; mm_n = 0; mm_used = 0;
    endtask

    task automatic wait_end;
        int i;
        for (i = 0; i < 3000; i++) begin
            if (o_done || o_error) break;
            tick(1);
        end
        chk("finished", 32'(o_done | o_error), 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    // ov9281_cfg model: answers each request 5 cycles after o_cfg_start
    initial begin
        logic [23:0] req;
        logic        is_rd, err;
        logic [7:0]  rd;
        i_cfg_done = 1'b0; i_cfg_error = 1'b0; i_cfg_rdata = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_cfg_start) begin
                req   = o_cfg_data[23:0];
                is_rd = o_cfg_read;
                chk("req_kind", 32'(o_cfg_write ^ o_cfg_read), 32'd1);
                if (!is_rd) begin
                    wr_data.push_back(req);
                    wr_cyc.push_back(cyc);
                end
                if (req != silent_key) begin
                    err = 1'b0;
                    rd  = req[7:0];
                    if (!is_rd && req == nack_key && nack_used < nack_n) begin
                        err = 1'b1;
                        nack_used++;
                    end
                    if (is_rd && req == mm_key && mm_used < mm_n) begin
                        rd = ~rd;
                        mm_used++;
                    end
                    repeat (5) @(posedge i_clk);
                    #1;
                    i_cfg_done = 1'b1; i_cfg_error = err; i_cfg_rdata = rd;
                    @(posedge i_clk);
                    #1;
                    i_cfg_done = 1'b0; i_cfg_error = 1'b0;
                end
            end
        end
    end

    initial begin
        int n_before;
        i_rst = 1'b1; i_start = 1'b0;
        tick(3);
        // reset state
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        chk("rst_start", 32'(o_cfg_start), 32'd0);
        chk("rst_data",  o_cfg_data, 32'd0);
        chk("rst_fidx",  32'(o_fail_idx), 32'd0);
        i_rst = 1'b0;
        tick(2);

        // 1 nominal
        clear_log();
        pulse_start();
        chk("t1_busy", 32'(o_busy), 32'd1);
        wait_end();
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_busy_end", 32'(o_busy), 32'd0);
        chk("t1_error", 32'(o_error), 32'd0);
        chk("t1_nwr", 32'(wr_data.size()), 32'd7);
        if (wr_data.size() == 7) begin
            for (int i = 0; i < 7; i++) chk($sformatf("t1_wr%0d", i), 32'(wr_data[i]), 32'(exp_wr[i]));
            chk("t1_gap_delay", 32'(wr_cyc[1] - wr_cyc[0] >= 40), 32'd1);
`ifndef OV9281_INIT_READBACK_EN
            chk("t1_gap_plain", 32'(wr_cyc[2] - wr_cyc[1]), 32'd9);
`endif
        end
        tick(3);

        // 2 retry: entry 3 NACKed once
        clear_log();
        nack_key = 24'h382040; nack_n = 1;
        pulse_start();
        chk("t2_done_clr", 32'(o_done), 32'd0);
        wait_end();
        chk("t2_done", 32'(o_done), 32'd1);
        chk("t2_nwr", 32'(wr_data.size()), 32'd8);
        if (wr_data.size() == 8) begin
            chk("t2_wr2", 32'(wr_data[2]), 32'h382040);
            chk("t2_wr3", 32'(wr_data[3]), 32'h382040);
            chk("t2_wr4", 32'(wr_data[4]), 32'h382100);
        end
        tick(3);

        // 3 fail: entry 4 NACKed every time
        clear_log();
        nack_key = 24'h382100; nack_n = 99;
        pulse_start();
        wait_end();
        chk("t3_error", 32'(o_error), 32'd1);
        chk("t3_done", 32'(o_done), 32'd0);
        chk("t3_fidx", 32'(o_fail_idx), 32'd4);
        chk("t3_busy", 32'(o_busy), 32'd0);
        chk("t3_attempts", 32'(nack_used), 32'd3);
        n_before = wr_data.size();
        chk("t3_nwr", 32'(n_before), 32'd6);
        tick(100);
        chk("t3_quiet", 32'(wr_data.size()), 32'(n_before));

        // 4 timeout: entry 2 never answered
        clear_log();
        silent_key = 24'h010000;
        pulse_start();
        wait_end();
        chk("t4_error", 32'(o_error), 32'd1);
        chk("t4_fidx", 32'(o_fail_idx), 32'd2);
        chk("t4_nwr", 32'(wr_data.size()), 32'd4);
        if (wr_data.size() == 4) begin
            chk("t4_period1", 32'(wr_cyc[2] - wr_cyc[1]), 32'd21);
            chk("t4_period2", 32'(wr_cyc[3] - wr_cyc[2]), 32'd21);
        end
        tick(30);

        // 5a: extra i_start pulses while busy are ignored
        clear_log();
        pulse_start();
        tick(3);
        pulse_start();
        tick(25);
        pulse_start();
        wait_end();
        chk("t5_done", 32'(o_done), 32'd1);
        chk("t5_nwr", 32'(wr_data.size()), 32'd7);
        tick(3);

        // 5b: reset during WAIT, stray done afterwards
        clear_log();
        pulse_start();
        for (int i = 0; i < 100 && wr_data.size() == 0; i++) tick(1);
        chk("t5_first_req", 32'(wr_data.size()), 32'd1);
        tick(2);
        i_rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_done", 32'(o_done), 32'd0);
        chk("t5_rst_data", o_cfg_data, 32'd0);
        tick(1);
        i_rst = 1'b0;
        tick(10);
        chk("t5_after_busy", 32'(o_busy), 32'd0);
        chk("t5_after_done", 32'(o_done | o_error), 32'd0);
        chk("t5_after_nwr", 32'(wr_data.size()), 32'd1);

`ifdef OV9281_INIT_READBACK_EN
        // 6 readback mismatch on entry 5 once
        clear_log();
        mm_key = 24'h4F0001; mm_n = 1;
        pulse_start();
        wait_end();
        chk("t6_done", 32'(o_done), 32'd1);
        chk("t6_nwr", 32'(wr_data.size()), 32'd8);
        if (wr_data.size() == 8) chk("t6_rewrite", 32'(wr_data[5]), 32'h4F0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
